// File: rtl/game_sequencer.sv
// Whack-a-mole game-flow controller: mode select, countdown, timed play and end-of-game hold.
// Buttons and whack are synchronised and edge-detected; all outputs come straight from flops.
module game_sequencer #(
   parameter int COUNTDOWN_S = 3,
   parameter int GAME_S      = 30,
   parameter int VAL_W       = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             tick_1hz_i,
   input  logic [3:0]       buttons_i,
   input  logic             whack_i,
   output logic [1:0]       mode_o,
   output logic             mole_enable_o,
   output logic [1:0]       state_o,
   output logic [VAL_W-1:0] time_left_o,
   output logic [VAL_W-1:0] score_o,
   output logic [VAL_W-1:0] display_value_o,
   output logic             game_done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01,
      ST_PLAY  = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [VAL_W-1:0] CD_LOAD   = VAL_W'(COUNTDOWN_S);
   localparam logic [VAL_W-1:0] GAME_LOAD = VAL_W'(GAME_S);
   localparam logic [VAL_W-1:0] ONE       = VAL_W'(1);
   localparam logic [VAL_W-1:0] SCORE_MAX = '1;

   // Bit 4 is whack, bits 3:0 are the buttons; stage 3 is the edge-detect history.
   logic [4:0] in_s1_q, in_s2_q, in_s3_q;
   logic [4:0] evt;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         in_s1_q <= '0;
         in_s2_q <= '0;
         in_s3_q <= '0;
      end else begin
         in_s1_q <= {whack_i, buttons_i};
         in_s2_q <= in_s1_q;
         in_s3_q <= in_s2_q;
      end
   end

   assign evt = in_s2_q & ~in_s3_q;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [VAL_W-1:0] time_q, time_d;
   logic [VAL_W-1:0] score_q, score_d;
   logic [VAL_W-1:0] disp_q, disp_d;
   logic             mole_q, mole_d;
   logic             done_q, done_d;
   logic [1:0]       mode_sel;
   logic             mode_evt;

   always_comb begin
      mode_sel = 2'b00;
      if (evt[0])      mode_sel = 2'b01;
      else if (evt[1]) mode_sel = 2'b10;
      else if (evt[2]) mode_sel = 2'b11;
   end

   assign mode_evt = |evt[2:0];

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      time_d  = time_q;
      score_d = score_q;
      done_d  = 1'b0;
      if (evt[3]) begin
         state_d = ST_IDLE;
         mode_d  = 2'b00;
         time_d  = '0;
         score_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (mode_evt) begin
                  state_d = ST_COUNT;
                  mode_d  = mode_sel;
                  time_d  = CD_LOAD;
                  score_d = '0;
               end
            end
            ST_COUNT: begin
               if (tick_1hz_i) begin
                  if (time_q == ONE) begin
                     state_d = ST_PLAY;
                     time_d  = GAME_LOAD;
                  end else if (time_q != '0) begin
                     time_d = time_q - ONE;
                  end
               end
            end
            ST_PLAY: begin
               if (evt[4] && (score_q != SCORE_MAX)) score_d = score_q + ONE;
               if (tick_1hz_i) begin
                  if (time_q == ONE) begin
                     state_d = ST_DONE;
                     time_d  = '0;
                     done_d  = 1'b1;
                  end else if (time_q != '0) begin
                     time_d = time_q - ONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      mole_d = (state_d == ST_PLAY);
      case (state_d)
         ST_COUNT, ST_PLAY: disp_d = time_d;
         ST_DONE:           disp_d = score_d;
         default:           disp_d = '0;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
         mode_q  <= 2'b00;
         time_q  <= '0;
         score_q <= '0;
         disp_q  <= '0;
         mole_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         time_q  <= time_d;
         score_q <= score_d;
         disp_q  <= disp_d;
         mole_q  <= mole_d;
         done_q  <= done_d;
      end
   end

   assign state_o         = state_q;
   assign mode_o          = mode_q;
   assign time_left_o     = time_q;
   assign score_o         = score_q;
   assign display_value_o = disp_q;
   assign mole_enable_o   = mole_q;
   assign game_done_o     = done_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed game scenarios plus random play,
// compared every cycle against a game-rule reference model.
module tb_game_sequencer;

   localparam int CD    = 3;
   localparam int GS    = 30;
   localparam int VAL_W = 16;
   localparam int SMAX  = (1 << VAL_W) - 1;

   logic             clock_i = 1'b0;
   logic             reset_i = 1'b0;
   logic             tick_1hz_i = 1'b0;
   logic [3:0]       buttons_i = 4'h0;
   logic             whack_i = 1'b0;
   logic [1:0]       mode_o;
   logic             mole_enable_o;
   logic [1:0]       state_o;
   logic [VAL_W-1:0] time_left_o;
   logic [VAL_W-1:0] score_o;
   logic [VAL_W-1:0] display_value_o;
   logic             game_done_o;

   game_sequencer #(.COUNTDOWN_S(CD), .GAME_S(GS), .VAL_W(VAL_W)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .tick_1hz_i(tick_1hz_i),
      .buttons_i(buttons_i), .whack_i(whack_i), .mode_o(mode_o),
      .mole_enable_o(mole_enable_o), .state_o(state_o), .time_left_o(time_left_o),
      .score_o(score_o), .display_value_o(display_value_o), .game_done_o(game_done_o)
   );

   always #5 clock_i = ~clock_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: game phase as 0 idle, 1 countdown, 2 play, 3 done.
   int         m_state, m_mode, m_time, m_score;
   bit         m_done;
   logic [4:0] hist [4];   // raw {whack, buttons} samples, [0] newest

   task automatic model_reset();
      m_state = 0; m_mode = 0; m_time = 0; m_score = 0; m_done = 0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
   endtask

   task automatic model_edge(input logic t, input logic [3:0] b, input logic w);
      logic [4:0] e;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {w, b};
      // a rise seen by the design two clocks after it was sampled
      e = hist[2] & ~hist[3];
      m_done = 0;
      if (e[3]) begin
         m_state = 0; m_mode = 0; m_time = 0; m_score = 0;
      end else if (m_state == 0 || m_state == 3) begin
         if (e[0] || e[1] || e[2]) begin
            m_mode  = e[0] ? 1 : (e[1] ? 2 : 3);
            m_time  = CD;
            m_score = 0;
            m_state = 1;
         end
      end else if (m_state == 1) begin
         if (t && m_time > 0) begin
            m_time--;
            if (m_time == 0) begin m_state = 2; m_time = GS; end
         end
      end else begin
         if (e[4] && m_score < SMAX) m_score++;
         if (t && m_time > 0) begin
            m_time--;
            if (m_time == 0) begin m_state = 3; m_done = 1; end
         end
      end
   endtask

   task automatic compare_all();
      int exp_disp;
      exp_disp = (m_state == 0) ? 0 : ((m_state == 3) ? m_score : m_time);
      check("state", state_o, m_state);
      check("mode", mode_o, m_mode);
      check("time_left", time_left_o, m_time);
      check("score", score_o, m_score);
      check("display", display_value_o, exp_disp);
      check("mole_en", mole_enable_o, (m_state == 2));
      check("game_done", game_done_o, m_done);
   endtask

   task automatic step(input logic t, input logic [3:0] b, input logic w);
      tick_1hz_i = t; buttons_i = b; whack_i = w;
      @(posedge clock_i);
      model_edge(t, b, w);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
   endtask

   task automatic press(input logic [3:0] b);
      step(1'b0, b, 1'b0); step(1'b0, b, 1'b0); step(1'b0, b, 1'b0);
      idle(2);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 4'h0, 1'b0);
   endtask

   task automatic whacks(input int n);
      for (int i = 0; i < n; i++) begin step(1'b0, 4'h0, 1'b1); step(1'b0, 4'h0, 1'b0); end
      idle(2);
   endtask

   int starts;
   logic [1:0] prev_state;

   initial begin
      model_reset();
      repeat (3) @(posedge clock_i);
      #1;
      compare_all();
      @(negedge clock_i);
      reset_i = 1'b1;

      // medium start, countdown into play
      press(4'b0010);
      check("tp2_mode", mode_o, 2);
      check("tp2_state", state_o, 1);
      check("tp2_time", time_left_o, CD);
      ticks(CD);
      check("tp2_play", state_o, 2);
      check("tp2_time30", time_left_o, GS);
      check("tp2_mole", mole_enable_o, 1);

      // five hits then full game time
      whacks(5);
      ticks(GS - 1);
      check("tp3_not_done", state_o, 2);
      ticks(1);
      check("tp3_done_state", state_o, 3);
      check("tp3_done_pulse", game_done_o, 1);
      check("tp3_disp", display_value_o, 5);
      check("tp3_mole", mole_enable_o, 0);
      idle(1);
      check("tp3_pulse_once", game_done_o, 0);
      check("tp3_score_held", score_o, 5);

      // easy+hard together from DONE, then abort mid-countdown
      press(4'b0101);
      check("tp5_mode", mode_o, 1);
      check("tp5_score", score_o, 0);
      check("tp5_state", state_o, 1);
      ticks(1);
      press(4'b1000);
      check("tp5_abort_state", state_o, 0);
      check("tp5_abort_mode", mode_o, 0);
      check("tp5_abort_time", time_left_o, 0);

      // whack coincident with the last play tick
      press(4'b0001);
      ticks(CD);
      whacks(4);
      ticks(GS - 1);
      step(1'b0, 4'h0, 1'b1);
      step(1'b0, 4'h0, 1'b0);
      step(1'b1, 4'h0, 1'b0);
      check("tp4_score", score_o, 5);
      check("tp4_state", state_o, 3);
      idle(2);

      // long hold of hard button from IDLE, tick coincident with the start
      press(4'b1000);
      starts = 0;
      for (int i = 0; i < 1000; i++) begin
         prev_state = state_o;
         step((i == 2), 4'b0100, 1'b0);
         if (prev_state == 2'b00 && state_o == 2'b01) starts++;
         if (i == 2) check("tp6_tick_ignored", time_left_o, CD);
      end
      check("tp6_starts", starts, 1);
      check("tp6_mode", mode_o, 3);
      idle(1);
      ticks(1);
      check("tp6_next_tick", time_left_o, CD - 1);

      // asynchronous reset in PLAY with score 7
      ticks(CD - 1);
      whacks(7);
      check("tp1_pre_score", score_o, 7);
      #3;
      reset_i = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clock_i);
      reset_i = 1'b1;
      idle(1);
      check("tp1_state", state_o, 0);
      check("tp1_disp", display_value_o, 0);

      // random play
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] b;
         b = 4'h0;
         if ($urandom_range(0, 29) == 0) b[2:0] = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 399) == 0) b[3] = 1'b1;
         step(($urandom_range(0, 5) == 0), b, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow controller for whack-a-mole. Sits between the button/tick sources (clock divider, buttons) and the mole, score and display stages.
- Runs mode selection, pre-game countdown, timed play and the end-of-game hold.
- Produces the active difficulty mode, the mole enable, time remaining, score, and the single value the BCD/seven-segment chain shows.
- Replaces ad-hoc mode/countdown/timer glue with one synchronous FSM on a single clock.

Parameters:
- COUNTDOWN_S, 3, pre-game countdown length in 1 Hz ticks; legal range ≥1.
- GAME_S, 30, play duration in 1 Hz ticks; legal range ≥1.
- VAL_W, 16, width of time_left_o, score_o and display_value_o.

Ports:
- clock_i  in  1  system clock; the only clock.
- reset_i  in  1  asynchronous, active-low reset.
- tick_1hz_i  in  1  one-clock_i-cycle pulse at 1 Hz, from the clock divider (enable, not a clock).
- buttons_i  in  4  raw push buttons: [0] easy, [1] medium, [2] hard, [3] abort.
- whack_i  in  1  whack indication from the whack checker; each rising edge is one hit.
- mode_o  out  2  selected mode: 00 none, 01 easy, 10 medium, 11 hard; selects mole rate.
- mole_enable_o  out  1  high only in PLAY.
- state_o  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 DONE.
- time_left_o  out  VAL_W  remaining ticks in the current phase.
- score_o  out  VAL_W  hits in the current or last game.
- display_value_o  out  VAL_W  binary value for the B2BCD stage.
- game_done_o  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- **Reset (asynchronous, reset_i=0):** state IDLE, mode_o=00, time_left_o=0, score_o=0, display_value_o=0, mole_enable_o=0, game_done_o=0. All synchroniser and edge-detect flops cleared.
- **Input conditioning:**
  - buttons_i and whack_i each pass through a 2-flop synchroniser, then a rising-edge detector. An edge event is a 1-cycle internal pulse, 3 cycles after the input rises.
  - Held inputs produce only one event.
- **Mode-button priority:** if several mode buttons have edge events in the same cycle, the lowest index wins (easy > medium > hard).
- **Abort:** a buttons_i[3] event in any state forces IDLE next cycle with the full reset values, except that synchroniser flops keep running. Abort has priority over every other event in that cycle.
- **IDLE:**
  - A mode event latches mode_o, loads time_left_o=COUNTDOWN_S, clears score_o, and goes to COUNTDOWN.
  - Ticks are ignored, including a tick coincident with the mode event; that tick does not decrement.
- **COUNTDOWN:**
  - Each tick decrements time_left_o.
  - A tick with time_left_o==1 goes to PLAY and loads time_left_o=GAME_S; mole_enable_o rises in that same cycle.
  - Mode events and whack events are ignored.
- **PLAY:**
  - Each whack event increments score_o, saturating at 2^VAL_W−1.
  - Each tick decrements time_left_o.
  - A tick with time_left_o==1 goes to DONE: time_left_o=0, mole_enable_o=0, game_done_o pulses for that one cycle.
  - A whack event in the same cycle as that final tick is counted.
  - Mode events are ignored.
- **DONE:**
  - score_o and mode_o are held.
  - A mode event behaves exactly as in IDLE (new game, score cleared).
  - Whack events and ticks are ignored.
- **display_value_o:** registered, updated in the same cycle as the state/counter registers.
  - IDLE: 0.
  - COUNTDOWN and PLAY: time_left_o.
  - DONE: score_o.
- **Timing:** all outputs are registered; no combinational path from inputs to outputs.
- **Counter safety:** time_left_o never underflows. A tick at time_left_o==0 outside COUNTDOWN/PLAY has no effect.

Test Plan:
1. Reset while in PLAY with score 7 → all outputs return to their reset values immediately (asynchronous). After release, state_o=00 and display_value_o=0.
2. Press buttons_i[1] in IDLE, defaults → mode_o=10, state_o=01, time_left_o=3. After 3 ticks: state_o=10, time_left_o=30, mole_enable_o=1.
3. In PLAY, 5 whack pulses, then 30 ticks → score_o=5; state_o=11 on the 30th tick; game_done_o high exactly one cycle; display_value_o=5; mole_enable_o=0.
4. Whack edge coincident with the final PLAY tick → score increments (4→5) and state_o=11 in the same update.
5. Press buttons_i[0] and [2] in the same cycle from DONE → mode_o=01, score_o=0, state_o=01. Then buttons_i[3] mid-countdown → state_o=00, mode_o=00, time_left_o=0.
6. Hold buttons_i[2] for 1000 cycles in IDLE → exactly one game start. Tick coincident with that start → time_left_o stays 3 until the next tick.
